instruction_mem: RTL and testbench

//  Instruction memory for the single-cycle RISC-V core; sits between the PC register and the decoder.

---
 rtl/instruction_mem_if.sv | 25 ++
 rtl/instruction_mem.sv | 59 +++++
 tb/tb_instruction_mem.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/instruction_mem_if.sv
// Read and program-load signals of the instruction memory.
// The master (PC/loader side) drives addresses and write data; the slave is the memory.
interface instruction_mem_if;
    logic [31:0] read_address;
    logic [31:0] instruction_code;
    logic        wr_en;
    logic [31:0] wr_address;
    logic [31:0] wr_data;

    modport master (
        output read_address,
        output wr_en,
        output wr_address,
        output wr_data,
        input  instruction_code
    );

    modport slave (
        input  read_address,
        input  wr_en,
        input  wr_address,
        input  wr_data,
        output instruction_code
    );
endinterface

// File: rtl/instruction_mem.sv
// Word-organised instruction store with combinational read and a clocked word write port.
// The boot program is reloaded asynchronously while reset is low.
module instruction_mem #(
    parameter int unsigned MEM_BYTES = 64,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input logic              clk,
    input logic              reset,
    instruction_mem_if.slave bus
);

    localparam int unsigned WORDS = MEM_BYTES / 4;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0] mem_q [WORDS];

    logic [29:0]      rd_word;
    logic [29:0]      wr_word;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_in_range;
    logic             wr_in_range;
    logic             unused_byte_offsets;

    // Byte offsets within a word play no part in addressing.
    assign unused_byte_offsets = ^{bus.read_address[1:0], bus.wr_address[1:0]};

    assign rd_word     = bus.read_address[31:2];
    assign wr_word     = bus.wr_address[31:2];
    assign rd_idx      = rd_word[IDX_W-1:0];
    assign wr_idx      = wr_word[IDX_W-1:0];
    assign rd_in_range = rd_word < 30'(WORDS);
    assign wr_in_range = wr_word < 30'(WORDS);

    function automatic logic [31:0] boot_word(input int unsigned idx);
        logic [31:0] w;
        case (idx)
            0:       w = 32'h0050_0093;  // addi x1,x0,5
            1:       w = 32'h0030_0113;  // addi x2,x0,3
            2:       w = 32'h0020_81B3;  // add  x3,x1,x2
            3:       w = 32'h4020_8233;  // sub  x4,x1,x2
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                mem_q[i] <= boot_word(i);
            end
        end else if (bus.wr_en && wr_in_range) begin
            mem_q[wr_idx] <= bus.wr_data;
        end
    end

    assign bus.instruction_code = rd_in_range ? mem_q[rd_idx] : NOP_WORD;

endmodule

// File: tb/tb_instruction_mem.sv
// Self-checking bench for instruction_mem: a byte-level little-endian model checked every
// falling clock edge, plus directed literal expectations.
module tb_instruction_mem;

    localparam int unsigned MEM_BYTES = 64;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    logic clk;
    logic reset;
    instruction_mem_if bus_if ();

    instruction_mem #(
        .MEM_BYTES(MEM_BYTES),
        .NOP_WORD (NOP_WORD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    int checks = 0;
    int errors = 0;
    bit armed  = 0;

    logic [7:0] model_mem [MEM_BYTES];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] boot_image(input int unsigned byte_addr);
        logic [31:0] w;
        case (byte_addr)
            0:       w = 32'h0050_0093;
            4:       w = 32'h0030_0113;
            8:       w = 32'h0020_81B3;
            12:      w = 32'h4020_8233;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] w);
        model_mem[a]     = w[7:0];
        model_mem[a + 1] = w[15:8];
        model_mem[a + 2] = w[23:16];
        model_mem[a + 3] = w[31:24];
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        if (a >= 32'(MEM_BYTES)) return NOP_WORD;
        return {model_mem[a + 3], model_mem[a + 2], model_mem[a + 1], model_mem[a]};
    endfunction

    // Model: reset reloads the boot image at once; writes land on rising edges out of reset.
    always @(negedge reset) begin
        for (int unsigned a = 0; a < MEM_BYTES; a += 4) model_store(a, boot_image(a));
    end

    always @(posedge clk) begin
        logic [31:0] a;
        a = {bus_if.wr_address[31:2], 2'b00};
        if (reset === 1'b1 && bus_if.wr_en === 1'b1 && a < 32'(MEM_BYTES)) begin
            model_store(a, bus_if.wr_data);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) check("model_cmp", bus_if.instruction_code, model_read(bus_if.read_address));
    end

    task automatic read_lit(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus_if.read_address = addr;
        #1;
        check(name, bus_if.instruction_code, exp);
    endtask

    // Drive one word write across a rising edge, checking old-then-new visibility at that word.
    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        #1;
        bus_if.wr_en        = 1'b1;
        bus_if.wr_address   = addr;
        bus_if.wr_data      = data;
        bus_if.read_address = addr;
        #1;
        check("rdw_before", bus_if.instruction_code, model_read(addr));
        @(posedge clk);
        #1;
        check("rdw_after", bus_if.instruction_code, model_read(addr));
        bus_if.wr_en = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t boot_vecs [8] = '{
        '{32'h0000_0000, 32'h0050_0093},
        '{32'h0000_0004, 32'h0030_0113},
        '{32'h0000_0008, 32'h0020_81B3},
        '{32'h0000_000C, 32'h4020_8233},
        '{32'h0000_0005, 32'h0030_0113},
        '{32'h0000_003C, 32'h0000_0000},
        '{32'h0000_0040, 32'h0000_0013},
        '{32'hFFFF_FFFC, 32'h0000_0013}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset               = 1'b1;
        bus_if.read_address = 32'h0;
        bus_if.wr_en        = 1'b0;
        bus_if.wr_address   = 32'h0;
        bus_if.wr_data      = 32'h0;
        #2;
        reset = 1'b0;
        #1;
        armed = 1'b1;
        read_lit("reset_hold_0", 32'h0, 32'h0050_0093);
        @(negedge clk);
        #1;
        reset = 1'b1;

        foreach (boot_vecs[i]) read_lit("boot_read", boot_vecs[i].addr, boot_vecs[i].exp);

        // Word 0x10 written; neighbour 0x0C must keep its boot value.
        write_word(32'h0000_0010, 32'hDEAD_BEEF);
        read_lit("wr_0x10", 32'h0000_0010, 32'hDEAD_BEEF);
        read_lit("keep_0x0C", 32'h0000_000C, 32'h4020_8233);

        // Asynchronous reset pulse between clock edges.
        bus_if.read_address = 32'h0000_0010;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", bus_if.instruction_code, 32'h0000_0000);
        #1;
        reset = 1'b1;

        // Out-of-range write dropped; misaligned write hits its aligned word.
        write_word(32'h0000_0040, 32'hCAFE_F00D);
        read_lit("oor_write_3C", 32'h0000_003C, 32'h0000_0000);
        read_lit("oor_write_40", 32'h0000_0040, 32'h0000_0013);
        write_word(32'h0000_0017, 32'h1122_3344);
        read_lit("misaligned_wr", 32'h0000_0015, 32'h1122_3344);

        // Write attempted while reset is held low is ignored.
        @(negedge clk);
        #1;
        reset             = 1'b0;
        bus_if.wr_en      = 1'b1;
        bus_if.wr_address = 32'h0;
        bus_if.wr_data    = 32'h1234_5678;
        @(posedge clk);
        #1;
        read_lit("wr_in_reset", 32'h0, 32'h0050_0093);
        bus_if.wr_en = 1'b0;
        #1;
        reset = 1'b1;
        read_lit("wr_in_reset2", 32'h0, 32'h0050_0093);

        for (int unsigned i = 0; i < 16; i++) begin
            write_word(i * 4 + (i % 4), (i * 32'h0101_0101) ^ 32'hA5A5_0000);
        end
        read_lit("sweep_w5", 32'h0000_0014, 32'hA0A0_0505);

        for (int unsigned a = 0; a < 72; a++) begin
            @(negedge clk);
            #1;
            bus_if.read_address = a;
        end
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
